// File: rtl/jala_stack_engine.sv
// Stack engine for the multicycle core: main data stack and return-address
// stack with their pointers, responding to push/pop/replace strobes from the
// control FSM. It exposes TOS/NOS to the ALU and return TOS to the PC mux,
// latches sticky overflow/underflow flags, and offers a registered peek port.
module jala_stack_engine #(
    parameter int DATA_W   = 16,
    parameter int MS_DEPTH = 32,
    parameter int RS_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ms_push,
    input  logic                        ms_pop,
    input  logic [DATA_W-1:0]           ms_wdata,
    input  logic                        rs_push,
    input  logic                        rs_pop,
    input  logic [DATA_W-1:0]           rs_wdata,
    output logic [DATA_W-1:0]           ms_tos,
    output logic [DATA_W-1:0]           ms_nos,
    output logic [DATA_W-1:0]           rs_tos,
    output logic [$clog2(MS_DEPTH):0]   ms_depth,
    output logic [$clog2(RS_DEPTH):0]   rs_depth,
    output logic                        ms_full,
    output logic                        ms_empty,
    output logic                        rs_full,
    output logic                        rs_empty,
    output logic                        overflow,
    output logic                        underflow,
    input  logic                        err_clr,
    input  logic                        pk_en,
    input  logic                        pk_sel,
    input  logic [$clog2(MS_DEPTH)-1:0] pk_idx,
    output logic [DATA_W-1:0]           pk_data,
    output logic                        pk_valid
);

    localparam int MS_AW = $clog2(MS_DEPTH);
    localparam int RS_AW = $clog2(RS_DEPTH);

    // Pointers carry one extra bit so a completely full stack is representable.
    localparam logic [MS_AW:0]   MS_CNT_ONE  = (MS_AW+1)'(1);
    localparam logic [MS_AW:0]   MS_CNT_TWO  = (MS_AW+1)'(2);
    localparam logic [MS_AW:0]   MS_CNT_FULL = (MS_AW+1)'(MS_DEPTH);
    localparam logic [MS_AW-1:0] MS_IDX_ONE  = MS_AW'(1);
    localparam logic [MS_AW-1:0] MS_IDX_TWO  = MS_AW'(2);
    localparam logic [RS_AW:0]   RS_CNT_ONE  = (RS_AW+1)'(1);
    localparam logic [RS_AW:0]   RS_CNT_FULL = (RS_AW+1)'(RS_DEPTH);
    localparam logic [RS_AW-1:0] RS_IDX_ONE  = RS_AW'(1);

    logic [DATA_W-1:0] ms_mem [MS_DEPTH];
    logic [DATA_W-1:0] rs_mem [RS_DEPTH];

    logic [MS_AW:0]    msp_q, msp_d;
    logic [RS_AW:0]    rsp_q, rsp_d;
    logic              overflow_q, underflow_q;
    logic [DATA_W-1:0] pk_data_q, pk_data_d;
    logic              pk_valid_q;

    logic              ms_we, rs_we;
    logic [MS_AW-1:0]  ms_waddr, ms_top_idx, ms_nos_idx;
    logic [RS_AW-1:0]  rs_waddr, rs_top_idx;
    logic              ms_ovf, ms_unf, rs_ovf, rs_unf;
    logic [31:0]       pk_idx_ext;

    // Status decode straight from the pointers; storage index is the low bits.
    assign ms_full    = (msp_q == MS_CNT_FULL);
    assign ms_empty   = (msp_q == '0);
    assign rs_full    = (rsp_q == RS_CNT_FULL);
    assign rs_empty   = (rsp_q == '0);
    assign ms_top_idx = msp_q[MS_AW-1:0] - MS_IDX_ONE;
    assign ms_nos_idx = msp_q[MS_AW-1:0] - MS_IDX_TWO;
    assign rs_top_idx = rsp_q[RS_AW-1:0] - RS_IDX_ONE;

    assign ms_tos    = ms_empty ? '0 : ms_mem[ms_top_idx];
    assign ms_nos    = (msp_q < MS_CNT_TWO) ? '0 : ms_mem[ms_nos_idx];
    assign rs_tos    = rs_empty ? '0 : rs_mem[rs_top_idx];
    assign ms_depth  = msp_q;
    assign rs_depth  = rsp_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign pk_data   = pk_data_q;
    assign pk_valid  = pk_valid_q;

    // Main stack command decode: replace beats push, push+pop on empty is a push.
    always_comb begin
        msp_d    = msp_q;
        ms_we    = 1'b0;
        ms_waddr = msp_q[MS_AW-1:0];
        ms_ovf   = 1'b0;
        ms_unf   = 1'b0;
        if (ms_push && ms_pop && !ms_empty) begin
            ms_we    = 1'b1;
            ms_waddr = ms_top_idx;
        end else if (ms_push) begin
            if (ms_full) begin
                ms_ovf = 1'b1;
            end else begin
                ms_we = 1'b1;
                msp_d = msp_q + MS_CNT_ONE;
            end
        end else if (ms_pop) begin
            if (ms_empty) begin
                ms_unf = 1'b1;
            end else begin
                msp_d = msp_q - MS_CNT_ONE;
            end
        end
    end

    // Return stack command decode, same rules as the main stack.
    always_comb begin
        rsp_d    = rsp_q;
        rs_we    = 1'b0;
        rs_waddr = rsp_q[RS_AW-1:0];
        rs_ovf   = 1'b0;
        rs_unf   = 1'b0;
        if (rs_push && rs_pop && !rs_empty) begin
            rs_we    = 1'b1;
            rs_waddr = rs_top_idx;
        end else if (rs_push) begin
            if (rs_full) begin
                rs_ovf = 1'b1;
            end else begin
                rs_we = 1'b1;
                rsp_d = rsp_q + RS_CNT_ONE;
            end
        end else if (rs_pop) begin
            if (rs_empty) begin
                rs_unf = 1'b1;
            end else begin
                rsp_d = rsp_q - RS_CNT_ONE;
            end
        end
    end

    // Peek lookup: anything at or above the live depth reads as zero.
    always_comb begin
        pk_data_d  = '0;
        pk_idx_ext = 32'(pk_idx);
        if (!pk_sel) begin
            if (pk_idx_ext < 32'(msp_q)) begin
                pk_data_d = ms_mem[pk_idx];
            end
        end else begin
            if (((pk_idx_ext >> RS_AW) == 32'd0) && (pk_idx_ext < 32'(rsp_q))) begin
                pk_data_d = rs_mem[pk_idx_ext[RS_AW-1:0]];
            end
        end
    end

    // Pointers and sticky error flags; a fresh error outranks a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            msp_q       <= '0;
            rsp_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            msp_q       <= msp_d;
            rsp_q       <= rsp_d;
            overflow_q  <= ms_ovf | rs_ovf | (overflow_q & ~err_clr);
            underflow_q <= ms_unf | rs_unf | (underflow_q & ~err_clr);
        end
    end

    // Main stack storage is never cleared, only written by accepted commands.
    always_ff @(posedge clk) begin
        if (!rst && ms_we) begin
            ms_mem[ms_waddr] <= ms_wdata;
        end
    end

    // Return stack storage, same write policy as the main stack.
    always_ff @(posedge clk) begin
        if (!rst && rs_we) begin
            rs_mem[rs_waddr] <= rs_wdata;
        end
    end

    // Registered peek result so a same-cycle write is seen as pre-edge data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pk_valid_q <= 1'b0;
            pk_data_q  <= '0;
        end else begin
            pk_valid_q <= pk_en;
            pk_data_q  <= pk_en ? pk_data_d : '0;
        end
    end

endmodule

// File: tb/tb_jala_stack_engine.sv
// Scoreboard bench for jala_stack_engine: directed commands push their
// hand-computed expectations into queues, and a monitor on the falling edge
// compares state each cycle and peek data whenever pk_valid is presented.
module tb_jala_stack_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ms_push = 1'b0, ms_pop = 1'b0;
    logic [15:0] ms_wdata = '0;
    logic        rs_push = 1'b0, rs_pop = 1'b0;
    logic [15:0] rs_wdata = '0;
    logic        err_clr = 1'b0, pk_en = 1'b0, pk_sel = 1'b0;
    logic [4:0]  pk_idx = '0;
    logic [15:0] ms_tos, ms_nos, rs_tos, pk_data;
    logic [5:0]  ms_depth;
    logic [4:0]  rs_depth;
    logic        ms_full, ms_empty, rs_full, rs_empty;
    logic        overflow, underflow, pk_valid;

    typedef enum int {F_MSTOS, F_MSNOS, F_RSTOS, F_MSDEPTH, F_RSDEPTH, F_MSFULL,
                      F_MSEMPTY, F_RSFULL, F_RSEMPTY, F_OVF, F_UNF, F_PKVALID} field_e;
    typedef struct { string name; int tgt; field_e fld; logic [15:0] val; } exp_t;
    typedef struct { string name; logic [15:0] val; } pk_t;

    exp_t stateQ[$];
    pk_t  pkQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   cycCnt  = 0;

    jala_stack_engine #(.DATA_W(16), .MS_DEPTH(32), .RS_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .ms_push(ms_push), .ms_pop(ms_pop), .ms_wdata(ms_wdata),
        .rs_push(rs_push), .rs_pop(rs_pop), .rs_wdata(rs_wdata),
        .ms_tos(ms_tos), .ms_nos(ms_nos), .rs_tos(rs_tos),
        .ms_depth(ms_depth), .rs_depth(rs_depth),
        .ms_full(ms_full), .ms_empty(ms_empty), .rs_full(rs_full), .rs_empty(rs_empty),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr),
        .pk_en(pk_en), .pk_sel(pk_sel), .pk_idx(pk_idx),
        .pk_data(pk_data), .pk_valid(pk_valid)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Cycle counter used to tag when each expectation becomes due.
    always @(posedge clk) cycCnt <= cycCnt + 1;

    function automatic logic [15:0] readField(input field_e f);
        case (f)
            F_MSTOS:   return ms_tos;
            F_MSNOS:   return ms_nos;
            F_RSTOS:   return rs_tos;
            F_MSDEPTH: return 16'(ms_depth);
            F_RSDEPTH: return 16'(rs_depth);
            F_MSFULL:  return 16'(ms_full);
            F_MSEMPTY: return 16'(ms_empty);
            F_RSFULL:  return 16'(rs_full);
            F_RSEMPTY: return 16'(rs_empty);
            F_OVF:     return 16'(overflow);
            F_UNF:     return 16'(underflow);
            default:   return 16'(pk_valid);
        endcase
    endfunction

    // Monitor: retire due state expectations and match each presented peek.
    always @(negedge clk) begin
        exp_t e;
        pk_t  p;
        logic [15:0] act;
        while (stateQ.size() > 0 && stateQ[0].tgt <= cycCnt) begin
            e   = stateQ.pop_front();
            act = readField(e.fld);
            nChecks++;
            if (act !== e.val) begin
                nFails++;
                $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", e.name, act, e.val);
            end
        end
        if (pk_valid === 1'b1) begin
            nChecks++;
            if (pkQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL pk_unexpected: got pk_valid=1 data 0x%04h, expected no peek", pk_data);
            end else begin
                p = pkQ.pop_front();
                if (pk_data !== p.val) begin
                    nFails++;
                    $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", p.name, pk_data, p.val);
                end
            end
        end
    end

    task automatic applyStimulus(input logic msPush, input logic msPop, input logic [15:0] msW,
                                 input logic rsPush, input logic rsPop, input logic [15:0] rsW,
                                 input logic errClr, input logic pkEn, input logic pkSel,
                                 input logic [4:0] pkIdx, input logic rstIn);
        @(negedge clk);
        ms_push = msPush;  ms_pop = msPop;  ms_wdata = msW;
        rs_push = rsPush;  rs_pop = rsPop;  rs_wdata = rsW;
        err_clr = errClr;  pk_en = pkEn;    pk_sel = pkSel;
        pk_idx  = pkIdx;   rst = rstIn;
    endtask

    // Expectation on DUT state after the edge that follows the last stimulus.
    task automatic checkOutput(input string name, input field_e f, input logic [15:0] val);
        exp_t e;
        e.name = name; e.tgt = cycCnt + 1; e.fld = f; e.val = val;
        stateQ.push_back(e);
    endtask

    task automatic checkPeek(input string name, input logic [15:0] val);
        pk_t p;
        p.name = name; p.val = val;
        pkQ.push_back(p);
    endtask

    task automatic msOp(input logic push, input logic pop, input logic [15:0] w);
        applyStimulus(push, pop, w, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic rsOp(input logic push, input logic pop, input logic [15:0] w);
        applyStimulus(1'b0, 1'b0, 16'h0, push, pop, w, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic peek(input logic sel, input logic [4:0] idx);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, sel, idx, 1'b0);
    endtask

    task automatic errClear();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        checkOutput("rst_msdepth", F_MSDEPTH, 16'h0);
        checkOutput("rst_rsdepth", F_RSDEPTH, 16'h0);
        checkOutput("rst_msempty", F_MSEMPTY, 16'h1);
        checkOutput("rst_rsempty", F_RSEMPTY, 16'h1);
        checkOutput("rst_mstos",   F_MSTOS,   16'h0);
        checkOutput("rst_rstos",   F_RSTOS,   16'h0);
        checkOutput("rst_ovf",     F_OVF,     16'h0);
        checkOutput("rst_unf",     F_UNF,     16'h0);
        checkOutput("rst_pkvalid", F_PKVALID, 16'h0);

        // Three pushes
        msOp(1, 0, 16'h1111);
        msOp(1, 0, 16'h2222);
        msOp(1, 0, 16'h3333);
        checkOutput("t1_depth", F_MSDEPTH, 16'd3);
        checkOutput("t1_tos",   F_MSTOS,   16'h3333);
        checkOutput("t1_nos",   F_MSNOS,   16'h2222);
        checkOutput("t1_empty", F_MSEMPTY, 16'h0);

        // Replace then two pops
        msOp(1, 1, 16'hABCD);
        checkOutput("t2_rep_depth", F_MSDEPTH, 16'd3);
        checkOutput("t2_rep_tos",   F_MSTOS,   16'hABCD);
        checkOutput("t2_rep_nos",   F_MSNOS,   16'h2222);
        msOp(0, 1, 16'h0);
        checkOutput("t2_pop1_tos", F_MSTOS, 16'h2222);
        msOp(0, 1, 16'h0);
        checkOutput("t2_pop2_tos",   F_MSTOS,   16'h1111);
        checkOutput("t2_pop2_nos",   F_MSNOS,   16'h0000);
        checkOutput("t2_pop2_depth", F_MSDEPTH, 16'd1);

        // Drain, then fill 0..31 and overflow
        msOp(0, 1, 16'h0);
        checkOutput("t3_empty", F_MSEMPTY, 16'h1);
        for (int i = 0; i < 32; i++) msOp(1, 0, 16'(i));
        checkOutput("t3_full",  F_MSFULL,  16'h1);
        checkOutput("t3_depth", F_MSDEPTH, 16'd32);
        checkOutput("t3_tos",   F_MSTOS,   16'd31);
        checkOutput("t3_ovf0",  F_OVF,     16'h0);
        msOp(1, 0, 16'hFFFF);
        checkOutput("t3_ovf_depth", F_MSDEPTH, 16'd32);
        checkOutput("t3_ovf_tos",   F_MSTOS,   16'd31);
        checkOutput("t3_ovf_flag",  F_OVF,     16'h1);
        applyStimulus(1, 0, 16'hFFFF, 0, 0, 0, 1'b1, 0, 0, 0, 0);
        checkOutput("t3_clr_vs_new", F_OVF, 16'h1);
        errClear();
        checkOutput("t3_clr", F_OVF, 16'h0);
        msOp(1, 1, 16'h7777);
        checkOutput("t3_fullrep_depth", F_MSDEPTH, 16'd32);
        checkOutput("t3_fullrep_tos",   F_MSTOS,   16'h7777);
        checkOutput("t3_fullrep_nos",   F_MSNOS,   16'd30);
        checkOutput("t3_fullrep_ovf",   F_OVF,     16'h0);
        applyStimulus(1, 1, 16'h8888, 0, 0, 0, 0, 1'b1, 1'b0, 5'd31, 0);
        checkPeek("pk_same_entry", 16'h7777);
        checkOutput("t3_rep2_tos", F_MSTOS, 16'h8888);
        peek(1'b0, 5'd1);
        checkPeek("pk_ms_idx1", 16'h0001);
        for (int i = 0; i < 32; i++) msOp(0, 1, 16'h0);
        checkOutput("t3_drain_empty", F_MSEMPTY, 16'h1);
        checkOutput("t3_drain_tos",   F_MSTOS,   16'h0);
        checkOutput("t3_drain_unf",   F_UNF,     16'h0);

        // Return underflow alongside an independent main push
        applyStimulus(1, 0, 16'h0005, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_unf",     F_UNF,     16'h1);
        checkOutput("t4_rsdepth", F_RSDEPTH, 16'h0);
        checkOutput("t4_msdepth", F_MSDEPTH, 16'd1);
        checkOutput("t4_mstos",   F_MSTOS,   16'h0005);
        checkOutput("t4_ovf",     F_OVF,     16'h0);
        errClear();
        checkOutput("t4_clr", F_UNF, 16'h0);

        // Jump-and-push: main pop with return push
        applyStimulus(0, 1, 0, 1, 0, 16'h0040, 0, 0, 0, 0, 0);
        checkOutput("t5_rstos",   F_RSTOS,   16'h0040);
        checkOutput("t5_msempty", F_MSEMPTY, 16'h1);
        checkOutput("t5_rsdepth", F_RSDEPTH, 16'd1);
        rsOp(0, 1, 16'h0);
        checkOutput("t5_rsempty", F_RSEMPTY, 16'h1);
        checkOutput("t5_rstos",   F_RSTOS,   16'h0);
        checkOutput("t5_unf",     F_UNF,     16'h0);

        // Return stack fill, peeks, overflow and full replace
        for (int i = 0; i < 16; i++) rsOp(1, 0, 16'h0100 + 16'(i));
        checkOutput("rs_full",  F_RSFULL,  16'h1);
        checkOutput("rs_depth", F_RSDEPTH, 16'd16);
        checkOutput("rs_tos",   F_RSTOS,   16'h010F);
        peek(1'b1, 5'd3);
        checkPeek("pk_rs_idx3", 16'h0103);
        peek(1'b1, 5'd16);
        checkPeek("pk_rs_idx16", 16'h0000);
        rsOp(1, 0, 16'h0999);
        checkOutput("rs_ovf",       F_OVF,     16'h1);
        checkOutput("rs_ovf_tos",   F_RSTOS,   16'h010F);
        checkOutput("rs_ovf_depth", F_RSDEPTH, 16'd16);
        rsOp(1, 1, 16'h0AAA);
        checkOutput("rs_rep_tos",   F_RSTOS,   16'h0AAA);
        checkOutput("rs_rep_depth", F_RSDEPTH, 16'd16);

        // Peeks on a two-deep main stack, then reset mid-push
        msOp(1, 0, 16'h0010);
        msOp(1, 0, 16'h0020);
        peek(1'b0, 5'd1);
        checkPeek("pk_ms_0x20", 16'h0020);
        checkOutput("t6_pkvalid", F_PKVALID, 16'h1);
        peek(1'b0, 5'd5);
        checkPeek("pk_ms_idx5", 16'h0000);
        applyStimulus(1, 0, 16'h0030, 1, 0, 16'h0031, 0, 1'b1, 1'b0, 5'd0, 1'b1);
        checkOutput("t6_rst_msdepth", F_MSDEPTH, 16'h0);
        checkOutput("t6_rst_rsdepth", F_RSDEPTH, 16'h0);
        checkOutput("t6_rst_pkvalid", F_PKVALID, 16'h0);
        checkOutput("t6_rst_ovf",     F_OVF,     16'h0);
        checkOutput("t6_rst_mstos",   F_MSTOS,   16'h0);

        msOp(0, 0, 16'h0);
        @(negedge clk);
        #1;
        if (stateQ.size() != 0 || pkQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: got %0d state and %0d peek pending, expected 0 and 0",
                     stateQ.size(), pkQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/jala_stack_engine.md
Name: jala_stack_engine

Overview:
- Datapath-side responder to the multicycle control FSM's stack strobes.
- Holds the main (data) stack and the return-address stack, together with their pointers.
- Executes push, pop and replace commands, and exposes top-of-stack (TOS) and next-on-stack (NOS) to the ALU, and return TOS to the PC mux.
- Flags overflow and underflow, and provides a 1-cycle-latency indexed peek port for the debug/test bench.

Parameters:
DATA_W, 16, word width of both stacks
MS_DEPTH, 32, main stack entries (power of 2, >=4)
RS_DEPTH, 16, return stack entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
ms_push  in  1  push ms_wdata onto main stack
ms_pop  in  1  pop main stack
ms_wdata  in  DATA_W  main stack write data
rs_push  in  1  push rs_wdata onto return stack
rs_pop  in  1  pop return stack
rs_wdata  in  DATA_W  return stack write data (return PC)
ms_tos  out  DATA_W  main stack entry msp-1, 0 when empty
ms_nos  out  DATA_W  main stack entry msp-2, 0 when depth<2
rs_tos  out  DATA_W  return stack entry rsp-1, 0 when empty
ms_depth  out  $clog2(MS_DEPTH)+1  main stack entry count
rs_depth  out  $clog2(RS_DEPTH)+1  return stack entry count
ms_full, ms_empty, rs_full, rs_empty  out  1 each  depth==DEPTH / depth==0
overflow  out  1  sticky: push attempted while full (either stack)
underflow  out  1  sticky: pop attempted while empty (either stack)
err_clr  in  1  clears overflow/underflow
pk_en  in  1  peek request
pk_sel  in  1  0=main stack, 1=return stack
pk_idx  in  $clog2(MS_DEPTH)  entry index from bottom (0 = oldest)
pk_data  out  DATA_W  peek result
pk_valid  out  1  peek result valid

Behaviour:
- Reset: msp=0, rsp=0, overflow=0, underflow=0, pk_valid=0, pk_data=0. Storage contents are not reset; all TOS/NOS outputs read 0 because the stacks are empty.
- Main stack command per cycle, evaluated on the clock edge using pre-edge msp:
  - push only, msp<MS_DEPTH: mem[msp]<=ms_wdata, msp<=msp+1.
  - pop only, msp>0: msp<=msp-1. Data is not cleared.
  - push+pop, msp>0 (replace): mem[msp-1]<=ms_wdata, msp unchanged.
  - push+pop, msp==0: treated as push, no underflow.
  - push while full (push only): ignored, overflow<=1.
  - pop while empty (pop only): ignored, underflow<=1.
  - Full stack with push+pop is a legal replace, not an overflow.
- Return stack: identical rules with rs_*, rsp and RS_DEPTH.
- Main and return stacks operate independently in the same cycle. This supports jump-and-push: main pop with return push in one cycle.
- ms_tos, ms_nos and rs_tos are combinational from storage and pointers. They reflect the new state in the cycle after the command edge, with zero extra latency.
- ms_depth and rs_depth are the pointer values. Flags are decoded combinationally from the pointers.
- Error flags:
  - Sticky until err_clr or rst.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag=1).
- Peek:
  - pk_en sampled at edge N gives pk_data = selected entry and pk_valid=1 after edge N.
  - pk_valid=0 after any edge where pk_en=0.
  - Index >= current depth of the selected stack returns 0 with pk_valid=1.
  - For pk_sel=1, the upper pk_idx bits beyond $clog2(RS_DEPTH) must be 0, otherwise the index is out of range (returns 0).
  - A peek in the same cycle as a write to the same entry returns pre-edge contents.
- Pointer arithmetic: depth counters are one bit wider than the index, so DEPTH is representable. Storage index is the low bits. There is no wrap-around, because guards prevent it.
- rst asserted mid-sequence takes priority over all commands in that cycle. Pointers go to 0 regardless of push/pop.

Test Plan:
1. Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles -> ms_depth=3, ms_tos=0x3333, ms_nos=0x2222, ms_empty=0.
2. From 1, assert push+pop with 0xABCD -> depth stays 3, ms_tos=0xABCD, ms_nos=0x2222. Then pop twice -> ms_tos=0x1111, ms_nos=0, depth=1.
3. Fill the main stack with 32 pushes (values 0..31) -> ms_full=1. 33rd push of 0xFFFF -> depth=32, ms_tos=31, overflow=1. err_clr -> overflow=0.
4. Pop on an empty return stack -> underflow=1, rs_depth=0. In the same cycle, main push 0x0005 -> ms_depth=1, unaffected.
5. rs_push 0x0040 together with ms_pop on a 1-deep main stack -> rs_tos=0x0040, ms_empty=1 after one edge. Then rs_pop -> rs_empty=1, rs_tos=0.
6. Main stack holds 0x10, 0x20. Peek pk_sel=0 pk_idx=1 -> pk_data=0x20, pk_valid=1 one cycle later. Peek pk_idx=5 -> pk_data=0, pk_valid=1. rst asserted mid-push -> ms_depth=0, pk_valid=0.
